// File: rtl/eth_rx_frame_fifo.sv
// Store-and-forward RX frame buffer: commits good frames, drops tuser-flagged or overflowing ones.
// Optional macro RX_FIFO_STATS_EN adds saturating good/bad/overflow frame counters.
module eth_rx_frame_fifo #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned FIFO_DEPTH = 4096
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata,
   input  logic                  s_axis_tvalid,
   input  logic                  s_axis_tlast,
   input  logic                  s_axis_tuser,
   output logic                  s_axis_trdy,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic                  m_axis_tvalid,
   output logic                  m_axis_tlast,
   input  logic                  m_axis_trdy,
   output logic                  drop_bad,
   output logic                  drop_ovf
`ifdef RX_FIFO_STATS_EN
   ,
   output logic [15:0]           stat_good_frames,
   output logic [15:0]           stat_bad_frames,
   output logic [15:0]           stat_ovf_frames
`endif
);

   localparam int unsigned ADDR_WIDTH = $clog2(FIFO_DEPTH);
   localparam int unsigned PTR_W      = ADDR_WIDTH + 1;
   localparam int unsigned ENT_W      = DATA_WIDTH + 1;

   typedef enum logic {ST_WRITE, ST_DROP} wr_state_e;

   wr_state_e         state_q, state_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  commit_ptr_q, commit_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic              err_q, err_d;
   logic              drop_bad_q, drop_bad_d;
   logic              drop_ovf_q, drop_ovf_d;
   logic              trdy_q;
   logic              rv_q, rv_d;
   logic              v0_q, v0_d, v1_q, v1_d;
   logic [ENT_W-1:0]  e0_q, e0_d, e1_q, e1_d;
   logic [ENT_W-1:0]  mem [FIFO_DEPTH];
   logic [ENT_W-1:0]  rd_data_q;

   logic              beat_c, full_c, empty_c, wr_en_c, pop_c, issue_c;
   logic [1:0]        occ_c;

   assign beat_c  = s_axis_tvalid && trdy_q;
   assign full_c  = (wr_ptr_q - rd_ptr_q) == PTR_W'(FIFO_DEPTH);
   assign empty_c = (rd_ptr_q == commit_ptr_q);

   // Write side: append beats, commit on good tlast, rewind to commit_ptr on any drop.
   always_comb begin
      state_d      = state_q;
      wr_ptr_d     = wr_ptr_q;
      commit_ptr_d = commit_ptr_q;
      err_d        = err_q;
      drop_bad_d   = 1'b0;
      drop_ovf_d   = 1'b0;
      wr_en_c      = 1'b0;
      case (state_q)
         ST_WRITE: begin
            if (beat_c) begin
               if (full_c) begin
                  if (s_axis_tlast) begin
                     wr_ptr_d   = commit_ptr_q;
                     err_d      = 1'b0;
                     drop_ovf_d = 1'b1;
                  end else begin
                     state_d = ST_DROP;
                  end
               end else begin
                  wr_en_c  = 1'b1;
                  wr_ptr_d = wr_ptr_q + PTR_W'(1);
                  if (s_axis_tlast) begin
                     if (err_q || s_axis_tuser) begin
                        wr_ptr_d   = commit_ptr_q;
                        err_d      = 1'b0;
                        drop_bad_d = 1'b1;
                     end else begin
                        commit_ptr_d = wr_ptr_q + PTR_W'(1);
                     end
                  end else if (s_axis_tuser) begin
                     err_d = 1'b1;
                  end
               end
            end
         end
         ST_DROP: begin
            if (beat_c && s_axis_tlast) begin
               wr_ptr_d   = commit_ptr_q;
               err_d      = 1'b0;
               drop_ovf_d = 1'b1;
               state_d    = ST_WRITE;
            end
         end
         default: state_d = ST_WRITE;
      endcase
   end

   // Read side: prefetch from the committed region into a 2-entry output register.
   always_comb begin
      pop_c    = v0_q && m_axis_trdy;
      occ_c    = {1'b0, v0_q} + {1'b0, v1_q} + {1'b0, rv_q};
      issue_c  = !empty_c && (occ_c <= (2'd1 + {1'b0, pop_c}));
      rd_ptr_d = rd_ptr_q + PTR_W'(issue_c);
      rv_d     = issue_c;
      v0_d     = v0_q;
      v1_d     = v1_q;
      e0_d     = e0_q;
      e1_d     = e1_q;
      if (pop_c) begin
         e0_d = e1_q;
         v0_d = v1_q;
         v1_d = 1'b0;
      end
      if (rv_q) begin
         if (!v0_d) begin
            e0_d = rd_data_q;
            v0_d = 1'b1;
         end else begin
            e1_d = rd_data_q;
            v1_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= ST_WRITE;
         wr_ptr_q     <= '0;
         commit_ptr_q <= '0;
         rd_ptr_q     <= '0;
         err_q        <= 1'b0;
         drop_bad_q   <= 1'b0;
         drop_ovf_q   <= 1'b0;
         trdy_q       <= 1'b0;
         rv_q         <= 1'b0;
         v0_q         <= 1'b0;
         v1_q         <= 1'b0;
         e0_q         <= '0;
         e1_q         <= '0;
      end else begin
         state_q      <= state_d;
         wr_ptr_q     <= wr_ptr_d;
         commit_ptr_q <= commit_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         err_q        <= err_d;
         drop_bad_q   <= drop_bad_d;
         drop_ovf_q   <= drop_ovf_d;
         trdy_q       <= 1'b1;
         rv_q         <= rv_d;
         v0_q         <= v0_d;
         v1_q         <= v1_d;
         e0_q         <= e0_d;
         e1_q         <= e1_d;
      end
   end

   // Frame storage, no reset; read data valid one cycle after issue.
   always_ff @(posedge clk) begin
      if (wr_en_c) begin
         mem[wr_ptr_q[ADDR_WIDTH-1:0]] <= {s_axis_tlast, s_axis_tdata};
      end
      if (issue_c) begin
         rd_data_q <= mem[rd_ptr_q[ADDR_WIDTH-1:0]];
      end
   end

   assign s_axis_trdy   = trdy_q;
   assign m_axis_tvalid = v0_q;
   assign m_axis_tdata  = e0_q[DATA_WIDTH-1:0];
   assign m_axis_tlast  = e0_q[DATA_WIDTH];
   assign drop_bad      = drop_bad_q;
   assign drop_ovf      = drop_ovf_q;

`ifdef RX_FIFO_STATS_EN
   logic [15:0] stat_good_q, stat_good_d;
   logic [15:0] stat_bad_q, stat_bad_d;
   logic [15:0] stat_ovf_q, stat_ovf_d;

   // Saturating frame counters.
   always_comb begin
      stat_good_d = stat_good_q;
      stat_bad_d  = stat_bad_q;
      stat_ovf_d  = stat_ovf_q;
      if ((commit_ptr_d != commit_ptr_q) && (stat_good_q != 16'hFFFF)) stat_good_d = stat_good_q + 16'd1;
      if (drop_bad_q && (stat_bad_q != 16'hFFFF)) stat_bad_d = stat_bad_q + 16'd1;
      if (drop_ovf_q && (stat_ovf_q != 16'hFFFF)) stat_ovf_d = stat_ovf_q + 16'd1;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stat_good_q <= '0;
         stat_bad_q  <= '0;
         stat_ovf_q  <= '0;
      end else begin
         stat_good_q <= stat_good_d;
         stat_bad_q  <= stat_bad_d;
         stat_ovf_q  <= stat_ovf_d;
      end
   end

   assign stat_good_frames = stat_good_q;
   assign stat_bad_frames  = stat_bad_q;
   assign stat_ovf_frames  = stat_ovf_q;
`endif

endmodule

// File: tb/tb_eth_rx_frame_fifo.sv
// Scoreboard bench for eth_rx_frame_fifo: frame-level model decides keep/drop, monitor checks output beats.
module tb_eth_rx_frame_fifo;

   localparam int unsigned DW    = 8;
   localparam int unsigned DEPTH = 256;

   logic          clk = 1'b0;
   logic          reset_n;
   logic [DW-1:0] s_axis_tdata;
   logic          s_axis_tvalid;
   logic          s_axis_tlast;
   logic          s_axis_tuser;
   logic          s_axis_trdy;
   logic [DW-1:0] m_axis_tdata;
   logic          m_axis_tvalid;
   logic          m_axis_tlast;
   logic          m_axis_trdy;
   logic          drop_bad;
   logic          drop_ovf;
`ifdef RX_FIFO_STATS_EN
   logic [15:0]   stat_good_frames, stat_bad_frames, stat_ovf_frames;
`endif

   eth_rx_frame_fifo #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .reset_n(reset_n),
      .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
      .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser), .s_axis_trdy(s_axis_trdy),
      .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
      .m_axis_tlast(m_axis_tlast), .m_axis_trdy(m_axis_trdy),
      .drop_bad(drop_bad), .drop_ovf(drop_ovf)
`ifdef RX_FIFO_STATS_EN
      , .stat_good_frames(stat_good_frames), .stat_bad_frames(stat_bad_frames),
      .stat_ovf_frames(stat_ovf_frames)
`endif
   );

   always #5 clk = ~clk;

   int         total = 0;
   int         bad = 0;
   logic [8:0] exp_q[$];
   int         exp_good = 0, exp_bad = 0, exp_ovf = 0;
   int         seen_bad = 0, seen_ovf = 0;
   int         base_good = 0, base_bad = 0, base_ovf = 0;
   int         trdy_mode = 1;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Output monitor: pops expected beats on each transfer and checks AXI hold rules.
   logic       prev_stall = 1'b0;
   logic [8:0] prev_beat = '0;
   logic [8:0] exp_beat;
   always @(negedge clk) begin
      if (reset_n) begin
         if (prev_stall) begin
            check("hold_valid", 32'(m_axis_tvalid), 32'd1);
            check("hold_beat", 32'({m_axis_tlast, m_axis_tdata}), 32'(prev_beat));
         end
         if (m_axis_tvalid && m_axis_trdy) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_beat: got %0h with no frame expected at %0t",
                        {m_axis_tlast, m_axis_tdata}, $time);
            end else begin
               exp_beat = exp_q.pop_front();
               check("out_beat", 32'({m_axis_tlast, m_axis_tdata}), 32'(exp_beat));
            end
         end
         prev_stall = m_axis_tvalid && !m_axis_trdy;
         prev_beat  = {m_axis_tlast, m_axis_tdata};
         if (drop_bad) seen_bad++;
         if (drop_ovf) seen_ovf++;
      end else begin
         prev_stall = 1'b0;
      end
   end

   // Downstream ready pattern: 0 hold low, 1 hold high, 2 toggle, 3 random.
   initial begin
      m_axis_trdy = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (trdy_mode)
            0:       m_axis_trdy = 1'b0;
            1:       m_axis_trdy = 1'b1;
            2:       m_axis_trdy = ~m_axis_trdy;
            default: m_axis_trdy = ($urandom_range(0, 1) == 1);
         endcase
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference model: a frame is lost to overflow if it cannot fit beside what is still
   // buffered, otherwise lost if any beat carried tuser, otherwise delivered intact.
   task automatic send_frame(input int len, input int start, input bit rnd, input int tuser_at,
                             input bit gaps);
      logic [7:0] data[$];
      logic [8:0] e;
      bit         err;
      int         buffered;
      err      = (tuser_at >= 0) && (tuser_at < len);
      buffered = exp_q.size();
      for (int i = 0; i < len; i++) data.push_back(rnd ? 8'($urandom) : 8'(start + i));
      if (len > int'(DEPTH) - buffered) begin
         exp_ovf++;
      end else if (err) begin
         exp_bad++;
      end else begin
         exp_good++;
         for (int i = 0; i < len; i++) begin
            e = {(i == len - 1), data[i]};
            exp_q.push_back(e);
         end
      end
      for (int i = 0; i < len; i++) begin
         if (gaps) begin
            s_axis_tvalid = 1'b0;
            repeat ($urandom_range(0, 2)) tick();
         end
         s_axis_tvalid = 1'b1;
         s_axis_tdata  = data[i];
         s_axis_tlast  = (i == len - 1);
         s_axis_tuser  = (i == tuser_at);
         tick();
      end
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      s_axis_tuser  = 1'b0;
   endtask

   task automatic wait_drain(input string nm);
      int n = 0;
      while (exp_q.size() != 0 && n < 4000) begin
         tick();
         n++;
      end
      repeat (4) tick();
      check({nm, "_drain"}, 32'(exp_q.size()), 32'd0);
      check({nm, "_drop_bad"}, 32'(seen_bad), 32'(exp_bad));
      check({nm, "_drop_ovf"}, 32'(seen_ovf), 32'(exp_ovf));
   endtask

   task automatic check_reset_outputs(input string nm);
      check({nm, "_m_tvalid"}, 32'(m_axis_tvalid), 32'd0);
      check({nm, "_m_tdata"}, 32'(m_axis_tdata), 32'd0);
      check({nm, "_m_tlast"}, 32'(m_axis_tlast), 32'd0);
      check({nm, "_s_trdy"}, 32'(s_axis_trdy), 32'd0);
      check({nm, "_drop_bad"}, 32'(drop_bad), 32'd0);
      check({nm, "_drop_ovf"}, 32'(drop_ovf), 32'd0);
   endtask

   initial begin
      int len;
      int tu;
      int guard;
      reset_n       = 1'b0;
      s_axis_tdata  = '0;
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      s_axis_tuser  = 1'b0;
      trdy_mode     = 1;
      repeat (3) tick();
      check_reset_outputs("por");
      reset_n = 1'b1;
      tick();
      check("trdy_after_reset", 32'(s_axis_trdy), 32'd1);

      // Single good frame, then bad frame followed by good frame.
      send_frame(64, 8'h00, 1'b0, -1, 1'b0);
      wait_drain("good64");
      send_frame(64, 8'h40, 1'b0, 63, 1'b0);
      send_frame(60, 8'hA0, 1'b0, -1, 1'b0);
      wait_drain("bad_then_good");

      // Commit-to-valid latency with downstream stalled.
      trdy_mode = 0;
      tick();
      send_frame(4, 8'h55, 1'b0, -1, 1'b0);
      repeat (2) tick();
      check("commit_latency_tvalid", 32'(m_axis_tvalid), 32'd1);
      trdy_mode = 1;
      wait_drain("latency");

      // Three 100-byte frames into a stalled 256-entry buffer: third overflows.
      trdy_mode = 0;
      tick();
      for (int f = 0; f < 3; f++) send_frame(100, f * 100, 1'b0, -1, 1'b0);
      repeat (4) tick();
      check("ovf3_pulse", 32'(seen_ovf), 32'(exp_ovf));
      trdy_mode = 1;
      wait_drain("ovf3");

      // Size boundaries: exactly DEPTH fits, DEPTH+1 with tuser is overflow only, oversize drops.
      send_frame(256, 8'h00, 1'b1, -1, 1'b0);
      wait_drain("depth_exact");
      send_frame(257, 8'h00, 1'b1, 256, 1'b0);
      send_frame(300, 8'h00, 1'b1, -1, 1'b0);
      send_frame(1, 8'h7E, 1'b0, -1, 1'b0);
      send_frame(1, 8'h7F, 1'b0, 0, 1'b0);
      send_frame(3, 8'h30, 1'b0, -1, 1'b0);
      wait_drain("boundaries");

      // Toggling downstream ready.
      trdy_mode = 2;
      send_frame(80, 8'h00, 1'b0, -1, 1'b0);
      send_frame(80, 8'h80, 1'b0, -1, 1'b0);
      wait_drain("toggle");

      // Reset in the middle of a frame; only the following frame may appear.
      trdy_mode = 1;
      for (int i = 0; i < 30; i++) begin
         s_axis_tvalid = 1'b1;
         s_axis_tdata  = 8'(i);
         s_axis_tlast  = 1'b0;
         s_axis_tuser  = 1'b0;
         tick();
      end
      reset_n       = 1'b0;
      s_axis_tvalid = 1'b0;
      #2;
      check_reset_outputs("mid_rst");
      tick();
      base_good = exp_good;
      base_bad  = exp_bad;
      base_ovf  = exp_ovf;
      reset_n = 1'b1;
      tick();
      check("trdy_after_mid_rst", 32'(s_axis_trdy), 32'd1);
      send_frame(64, 8'h10, 1'b0, -1, 1'b0);
      wait_drain("after_rst");

      // Randomized frames, gaps, errors and ready, throttled to stay clear of overflow.
      trdy_mode = 3;
      for (int f = 0; f < 40; f++) begin
         len   = $urandom_range(1, 70);
         tu    = ($urandom_range(0, 3) == 0) ? $urandom_range(0, len - 1) : -1;
         guard = 0;
         while (exp_q.size() + len > 200 && guard < 4000) begin
            tick();
            guard++;
         end
         check("throttle_timeout", 32'(guard < 4000), 32'd1);
         send_frame(len, 0, 1'b1, tu, 1'b1);
      end
      trdy_mode = 1;
      wait_drain("random");

`ifdef RX_FIFO_STATS_EN
      check("stat_good", 32'(stat_good_frames), 32'(exp_good - base_good));
      check("stat_bad", 32'(stat_bad_frames), 32'(exp_bad - base_bad));
      check("stat_ovf", 32'(stat_ovf_frames), 32'(exp_ovf - base_ovf));
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
